// File: rtl/sram_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_pkg
// Purpose  : Shared types and constants for the SRAM-to-AXI3 bridge.
//            Holds the read/write FSM state encodings, the AXI ID assignment
//            of the two requesters and the fixed burst attributes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sram_axi_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW   = 2'd1,
    WR_B    = 2'd2
  } wr_state_t;

  localparam logic [3:0] AXI_ID_INST    = 4'd0;
  localparam logic [3:0] AXI_ID_DATA    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

endpackage
`default_nettype wire

// File: rtl/sram_axi_arbiter_wr_chan.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_wr_chan
// Purpose  : Single-beat AXI3 write sequencer. Latches one data-port write,
//            drives AW and W concurrently (each channel drops its valid on
//            its own handshake), then waits for B.
// Ports    : clk, reset        - clock, async active-high reset
//            start             - accept a write (only asserted while idle)
//            req_addr/size/wstrb/wdata - write request payload
//            awaddr/awsize/awvalid/awready - AW channel
//            wdata/wstrb/wvalid/wready     - W channel
//            bvalid/bready     - B channel
//            busy              - a write is outstanding (WR_AW or WR_B)
//            done              - B handshake this cycle (data_ok source)
// Revision : 1.0 - initial release
// ============================================================================
module sram_axi_wr_chan
  import sram_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic        busy,
  output logic        done
);

  wr_state_t  state, state_nxt;
  logic       aw_done, w_done;   // channel handshake already completed
  logic [1:0] size_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WR_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      awaddr  <= 32'd0;
      size_q  <= 2'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (start) begin
        awaddr  <= req_addr;
        size_q  <= req_size;
        wdata   <= req_wdata;
        wstrb   <= req_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    done      = 1'b0;
    case (state)
      WR_IDLE: if (start) state_nxt = WR_AW;
      WR_AW: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        // Leave once each channel has either finished earlier or finishes now.
        if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          done      = 1'b1;
          state_nxt = WR_IDLE;
        end
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  assign busy   = (state != WR_IDLE);
  assign awsize = {1'b0, size_q};

endmodule
`default_nettype wire

// File: rtl/sram_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_arbiter
// Purpose  : Bridges the instruction and data SRAM-like ports onto one 32-bit
//            AXI3 master. Reads are arbitrated (data first) through a single
//            read FSM; data writes go through sram_axi_wr_chan. At most one
//            read and one write are outstanding.
// Config   : SRAM_AXI_RAW_ADDR_EN - when defined, an instruction read is held
//            off only if its word address matches the pending write; when
//            undefined, any outstanding write holds instruction reads off.
// Ports    : clk, reset (async, active-high)
//            inst_sram_*  - instruction fetch port (read only)
//            data_sram_*  - data load/store port
//            ar*/r*       - AXI read address / read data channels
//            aw*/w*/b*    - AXI write address / data / response channels
// Revision : 1.0 - initial release
// ============================================================================
module sram_axi_arbiter
  import sram_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_t   rd_state, rd_state_nxt;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic [3:0]  rd_id;
  logic        rd_ok_data, rd_ok_inst;

  logic wr_busy, wr_done, wr_start;
  logic data_rd_req, data_wr_req, data_rd_pending, data_busy;
  logic data_rd_grant, inst_rd_grant, inst_raw_block;

  assign data_rd_req     = data_sram_req & ~data_sram_wr;
  assign data_wr_req     = data_sram_req &  data_sram_wr;
  assign data_rd_pending = (rd_state != RD_IDLE) && (rd_id == AXI_ID_DATA);
  // Any outstanding data transaction stalls the data port: keeps responses in order.
  assign data_busy       = data_rd_pending | wr_busy;

`ifdef SRAM_AXI_RAW_ADDR_EN
  assign inst_raw_block = wr_busy && (inst_sram_addr[31:2] == awaddr[31:2]);
`else
  assign inst_raw_block = wr_busy;
`endif

  assign data_rd_grant = ~reset & data_rd_req & ~data_busy & (rd_state == RD_IDLE);
  assign inst_rd_grant = ~reset & inst_sram_req & ~data_rd_grant & ~inst_raw_block
                       & (rd_state == RD_IDLE);
  assign wr_start      = ~reset & data_wr_req & ~data_busy;

  assign inst_sram_addr_ok = inst_rd_grant;
  assign data_sram_addr_ok = data_rd_grant | wr_start;

  // Read FSM: state and latched request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rd_addr  <= 32'd0;
      rd_size  <= 2'd0;
      rd_id    <= AXI_ID_INST;
    end else begin
      rd_state <= rd_state_nxt;
      if (data_rd_grant) begin
        rd_addr <= data_sram_addr;
        rd_size <= data_sram_size;
        rd_id   <= AXI_ID_DATA;
      end else if (inst_rd_grant) begin
        rd_addr <= inst_sram_addr;
        rd_size <= inst_sram_size;
        rd_id   <= AXI_ID_INST;
      end
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    rd_ok_data   = 1'b0;
    rd_ok_inst   = 1'b0;
    case (rd_state)
      RD_IDLE: if (data_rd_grant || inst_rd_grant) rd_state_nxt = RD_AR;
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) rd_state_nxt = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          rd_ok_data   = (rid == AXI_ID_DATA);
          rd_ok_inst   = (rid == AXI_ID_INST);
          rd_state_nxt = RD_IDLE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  sram_axi_wr_chan u_wr_chan (
    .clk       (clk),
    .reset     (reset),
    .start     (wr_start),
    .req_addr  (data_sram_addr),
    .req_size  (data_sram_size),
    .req_wstrb (data_sram_wstrb),
    .req_wdata (data_sram_wdata),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready),
    .busy      (wr_busy),
    .done      (wr_done)
  );

  // Read data and write response can never both belong to the data port.
  assign inst_sram_data_ok = rd_ok_inst;
  assign data_sram_data_ok = rd_ok_data | wr_done;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arid    = rd_id;
  assign araddr  = rd_addr;
  assign arsize  = {1'b0, rd_size};
  assign arlen   = AXI_LEN_SINGLE[3:0];
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = AXI_ID_DATA;
  assign awlen   = AXI_LEN_SINGLE[3:0];
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID_DATA;
  assign wlast   = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           rresp, rlast, bid, bresp};

endmodule
`default_nettype wire
